// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage.
// Requests words from instruction memory, delivers them through a one-entry
// output register, parks one early response in a pending buffer while the
// consumer stalls, and handles redirects, including one that arrives while a
// memory request is still outstanding.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   stall                   consumer not accepting; output register holds
//   redirect, redirect_pc   taken branch/jump and its target
//   mem_req, mem_addr       instruction memory request and word address
//   mem_ready, mem_data     memory response strobe and instruction word
//   instr, op_code, funct   delivered instruction and its decoded fields
//   pc_out, pc_plus4        address of instr and the following address
//   valid                   instr holds a live instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic [5:0]  funct,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] drain_addr_q;   // address of the request being drained
    logic [31:0] instr_q, pc_out_q;
    logic        valid_q;
    logic [31:0] pend_instr_q, pend_pc_q;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~32'h0000_0003;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect takes priority over stall and mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (redirect) begin
                    // An outstanding request cannot be aborted, so drain it
                    state_d = mem_ready ? StFetch : StDrain;
                end else if (mem_ready && stall) begin
                    state_d = StHold;
                end
            end
            StHold:  if (redirect || !stall) state_d = StFetch;
            StDrain: if (mem_ready) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // Outputs of the FSM
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            StFetch: mem_req = 1'b1;
            StDrain: begin
                mem_req  = 1'b1;
                mem_addr = drain_addr_q;
            end
            default: ;
        endcase
    end

    // Datapath: pc, output register and pending buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            pend_instr_q <= '0;
            pend_pc_q    <= '0;
        end else begin
            case (state_q)
                StIdle: if (redirect) pc_q <= redirect_tgt;
                StFetch: begin
                    if (redirect) begin
                        pc_q    <= redirect_tgt;
                        valid_q <= 1'b0;
                        if (!mem_ready) drain_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        pc_q <= pc_q + 32'd4;
                        if (stall) begin
                            // Output register is occupied; park the word
                            pend_instr_q <= mem_data;
                            pend_pc_q    <= pc_q;
                        end else begin
                            instr_q  <= mem_data;
                            pc_out_q <= pc_q;
                            valid_q  <= 1'b1;
                        end
                    end else if (!stall) begin
                        // Consumer took the old word and nothing replaces it
                        valid_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        // Pending entry is dropped by simply not using it
                        pc_q    <= redirect_tgt;
                        valid_q <= 1'b0;
                    end else if (!stall) begin
                        instr_q  <= pend_instr_q;
                        pc_out_q <= pend_pc_q;
                        valid_q  <= 1'b1;
                    end
                end
                StDrain: if (redirect) pc_q <= redirect_tgt;
                default: ;
            endcase
        end
    end

    assign instr    = instr_q;
    assign pc_out   = pc_out_q;
    assign valid    = valid_q;
    assign op_code  = instr_q[31:26];
    assign funct    = instr_q[5:0];
    assign pc_plus4 = pc_out_q + 32'd4;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  in  1  downstream is not accepting; the output register holds.
REQ-005 SHALL have port redirect  in  1  branch or jump taken; flush and refetch.
REQ-006 SHALL have port redirect_pc  in  32  target address of the redirect.
REQ-007 SHALL have port mem_req  out  1  instruction memory request.
REQ-008 SHALL have port mem_addr  out  32  request address, word-aligned.
REQ-009 SHALL have port mem_ready  in  1  memory returns mem_data this cycle; meaningful only while mem_req=1.
REQ-010 SHALL have port mem_data  in  32  instruction word.
REQ-011 SHALL have port instr  out  32  delivered instruction.
REQ-012 SHALL have port op_code  out  6  instr[31:26].
REQ-013 SHALL have port funct  out  6  instr[5:0].
REQ-014 SHALL have port pc_out  out  32  address of instr.
REQ-015 SHALL have port pc_plus4  out  32  pc_out+4.
REQ-016 SHALL have port valid  out  1  instr holds a live instruction.

Function
REQ-017 SHALL implement the states IDLE, FETCH, HOLD and DRAIN.
REQ-018 SHALL hold mem_req=0 in IDLE and go from IDLE to FETCH on the first edge after reset is released.
REQ-019 SHALL, in FETCH, drive mem_req=1 and mem_addr=pc, keeping both stable until mem_ready.
REQ-020 SHALL, in FETCH with mem_ready=1, stall=0 and redirect=0, load instr=mem_data and pc_out=pc, set valid=1, set pc<=pc+4 and stay in FETCH.
REQ-021 SHALL, in FETCH with mem_ready=1, stall=1 and redirect=0, capture mem_data and pc into a one-entry pending buffer, set pc<=pc+4 and go to HOLD.
REQ-022 SHALL leave instr, pc_out and valid unchanged during that capture.
REQ-023 SHALL, in HOLD, drive mem_req=0.
REQ-024 SHALL, in HOLD when stall falls, move the pending entry to the output register with valid=1 and return to FETCH.
REQ-025 SHALL, in FETCH with stall=0 and mem_ready=0, clear valid on that edge, meaning the consumer took the old instruction.
REQ-026 SHALL keep valid and instr unchanged whenever stall=1.
REQ-027 SHALL give redirect priority over stall and mem_ready in every state.
REQ-028 SHALL, on redirect, set pc<=redirect_pc with bits [1:0] forced to 00, set valid<=0 and discard the pending entry.
REQ-029 SHALL, on redirect in FETCH with mem_ready=0, go to DRAIN, because an outstanding request cannot be aborted.
REQ-030 SHALL, in DRAIN, hold mem_req=1 with the old mem_addr until mem_ready, discard that data, then enter FETCH at the new pc.
REQ-031 SHALL, on a further redirect during DRAIN, update the target pc and stay in DRAIN.
REQ-032 SHALL, on redirect in FETCH with mem_ready=1, discard mem_data and re-enter FETCH at the new pc.
REQ-033 SHALL, on redirect in HOLD or IDLE, go to FETCH at the new pc.
REQ-034 SHALL compute pc increment modulo 2^32, so 32'hFFFF_FFFC+4 gives 32'h0000_0000; pc_plus4 wraps the same way.
REQ-035 SHALL derive op_code, funct and pc_plus4 combinationally from the output register only.
REQ-036 SHALL have a latency of one edge from mem_ready to valid when not stalled.
REQ-037 SHALL sustain throughput of one instruction per cycle when mem_ready is held at 1.

Reset
REQ-038 SHALL, while reset=1 and regardless of clk, force state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr=0, pc_out=0, valid=0 and the pending buffer empty.
REQ-039 SHALL, on reset asserted mid-request (FETCH or DRAIN), abandon the request with mem_req=0 immediately and drop all in-flight data.

Verification
REQ-040 SHALL cover: reset release, mem_ready=1 constant, mem_data=32'h0000_0020 -> mem_addr 0x00400000, 0x00400004, ... each cycle; valid=1 from the second post-reset edge; op_code=0, funct=6'h20.
REQ-041 SHALL cover: stall=1 for 3 cycles while a response arrives -> instr unchanged, mem_req=0 in HOLD; after stall drops, the pending word appears next edge with its pc_out; no word lost or duplicated.
REQ-042 SHALL cover: redirect to 0x00400103 with mem_ready=0 -> DRAIN holds the old mem_addr; the drained data is not delivered; the next mem_addr is 0x00400100; valid=0 meanwhile.
REQ-043 SHALL cover: redirect and stall asserted together while valid=1 -> valid=0 after the edge; the pending entry is discarded.
REQ-044 SHALL cover: redirect to 0xFFFFFFFC, then one fetch -> pc_plus4=0 and the next mem_addr=0x00000000.
REQ-045 SHALL cover: reset asserted between clock edges during DRAIN -> mem_req=0 and valid=0 immediately; restart at RESET_PC.
